// File: rtl/wb_mailbox_pkg.sv
// Shared state encoding, register-map helpers and constants for the
// Wishbone mailbox bridge.
package wb_mailbox_pkg;

  typedef logic [1:0] mb_state_t;

  localparam mb_state_t ST_IDLE = 2'd0;
  localparam mb_state_t ST_WAIT = 2'd1;
  localparam mb_state_t ST_ACK  = 2'd2;

  localparam int          C2H_VALID_LSB = 16;
  localparam logic [31:0] BAD_READ      = 32'hFFFF_FFFF;

  function automatic int STATUS_IDX(input int num_ch);
    return 2 * num_ch;
  endfunction

  function automatic int IRQEN_IDX(input int num_ch);
    return 2 * num_ch + 1;
  endfunction

  // Replace only the bytes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mailbox_chan.sv
// One mailbox channel: a host-to-core word and a core-to-host word, each
// with its valid flag and the same-edge priority rules.
module mailbox_chan
  import wb_mailbox_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        host_wr,
  input  logic [3:0]  host_sel,
  input  logic [31:0] host_dat,
  input  logic        host_rd_clr,
  input  logic        core_take,
  input  logic        core_we,
  input  logic [31:0] core_dat,
  output logic [31:0] h2c_word,
  output logic        h2c_valid,
  output logic [31:0] c2h_word,
  output logic        c2h_valid
);

  // A host write beats a same-edge take; a core write beats a same-edge read-clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      h2c_word  <= '0;
      h2c_valid <= 1'b0;
      c2h_word  <= '0;
      c2h_valid <= 1'b0;
    end else begin
      if (host_wr) begin
        h2c_word  <= byte_merge(h2c_word, host_dat, host_sel);
        h2c_valid <= 1'b1;
      end else if (core_take) begin
        h2c_valid <= 1'b0;
      end

      if (core_we) begin
        c2h_word  <= core_dat;
        c2h_valid <= 1'b1;
      end else if (host_rd_clr) begin
        c2h_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_mailbox_bridge.sv
// Wishbone slave exposing NUM_CH bidirectional mailbox channels, a status
// word and an interrupt enable register, with programmable ack latency.
//   state   | meaning
//   ST_IDLE | waiting for cyc&stb; captures the request
//   ST_WAIT | counting down ACK_DELAY; aborts if cyc&stb drops
//   ST_ACK  | one-cycle ack; side effects committed on entry
module wb_mailbox_bridge
  import wb_mailbox_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ACK_DELAY = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  output logic [32*NUM_CH-1:0] h2c_data,
  output logic [NUM_CH-1:0]   h2c_valid,
  input  logic [NUM_CH-1:0]   h2c_take,
  input  logic [32*NUM_CH-1:0] c2h_data,
  input  logic [NUM_CH-1:0]   c2h_we,
  output logic [NUM_CH-1:0]   c2h_valid,
  output logic                irq
);

  mb_state_t         state;
  logic [3:0]        cnt;
  logic [5:0]        adr_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;
  logic [NUM_CH-1:0] irq_en;

  logic              req;
  logic              commit;
  logic [5:0]        eff_idx;
  logic              eff_we;
  logic [3:0]        eff_sel;
  logic [31:0]       eff_dat;
  logic [31:0]       status_w;
  logic [31:0]       rd_mux;
  logic [31:0]       h2c_word [NUM_CH];
  logic [31:0]       c2h_word [NUM_CH];
  logic              unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  assign req = wbs_cyc_i & wbs_stb_i;

  // With zero delay the commit happens on the capture edge, so decode the live bus.
  assign eff_idx = (state == ST_IDLE) ? wbs_adr_i[7:2] : adr_q;
  assign eff_we  = (state == ST_IDLE) ? wbs_we_i       : we_q;
  assign eff_sel = (state == ST_IDLE) ? wbs_sel_i      : sel_q;
  assign eff_dat = (state == ST_IDLE) ? wbs_dat_i      : dat_q;

  assign commit = req & (((state == ST_IDLE) & (ACK_DELAY == 0)) |
                         ((state == ST_WAIT) & (cnt == 4'd1)));

  assign irq = |(c2h_valid & irq_en);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic hit_h2c;
    logic hit_c2h;

    assign hit_h2c = (eff_idx == 6'(i));
    assign hit_c2h = (eff_idx == 6'(NUM_CH + i));

    mailbox_chan u_chan (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .host_wr     (commit & eff_we & hit_h2c),
      .host_sel    (eff_sel),
      .host_dat    (eff_dat),
      .host_rd_clr (commit & ~eff_we & hit_c2h),
      .core_take   (h2c_take[i]),
      .core_we     (c2h_we[i]),
      .core_dat    (c2h_data[32*i +: 32]),
      .h2c_word    (h2c_word[i]),
      .h2c_valid   (h2c_valid[i]),
      .c2h_word    (c2h_word[i]),
      .c2h_valid   (c2h_valid[i])
    );

    assign h2c_data[32*i +: 32] = h2c_word[i];
  end

  always_comb begin
    status_w = '0;
    status_w[NUM_CH-1:0] = h2c_valid;
    status_w[C2H_VALID_LSB +: NUM_CH] = c2h_valid;
  end

  always_comb begin
    rd_mux = BAD_READ;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eff_idx == 6'(i))          rd_mux = h2c_word[i];
      if (eff_idx == 6'(NUM_CH + i)) rd_mux = c2h_word[i];
    end
    if (eff_idx == 6'(STATUS_IDX(NUM_CH))) rd_mux = status_w;
    if (eff_idx == 6'(IRQEN_IDX(NUM_CH)))  rd_mux = 32'(irq_en);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= BAD_READ;
      irq_en    <= '0;
    end else begin
      wbs_ack_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req) begin
            adr_q <= wbs_adr_i[7:2];
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            dat_q <= wbs_dat_i;
            cnt   <= 4'(ACK_DELAY);
            state <= (ACK_DELAY == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (!req)              state <= ST_IDLE;
          else if (cnt == 4'd1)  state <= ST_ACK;
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (commit) begin
        wbs_ack_o <= 1'b1;
        if (!eff_we) begin
          wbs_dat_o <= rd_mux;
        end else if (eff_idx == 6'(IRQEN_IDX(NUM_CH))) begin
          for (int b = 0; b < NUM_CH; b++) begin
            if (eff_sel[2'(b / 8)]) irq_en[b] <= eff_dat[b];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mailbox_bridge.sv
// Directed plus randomized checks of wb_mailbox_bridge against a
// register-level reference model; several parameter sets run side by side.
module tb_wb_mailbox_bridge;

  localparam int NI   = 8;
  localparam int MAIN = 7;

  function automatic int cfg_nc(input int g);
    case (g)
      0, 1:    return 1;
      4, 5:    return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_ad(input int g);
    case (g)
      0, 2, 4: return 0;
      1, 3, 5: return 3;
      6:       return 4;
      default: return 1;
    endcase
  endfunction

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  logic          b_cyc [NI];
  logic          b_stb [NI];
  logic          b_we  [NI];
  logic [3:0]    b_sel [NI];
  logic [31:0]   b_adr [NI];
  logic [31:0]   b_dat [NI];
  logic [NI-1:0] b_ack;
  logic [32*NI-1:0] b_rdat;

  logic [127:0] h2c_data;
  logic [3:0]   h2c_valid;
  logic [3:0]   h2c_take;
  logic [127:0] c2h_data;
  logic [3:0]   c2h_we;
  logic [3:0]   c2h_valid;
  logic         irq;

  wb_mailbox_bridge #(.NUM_CH(4), .ACK_DELAY(1)) u_main (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (b_cyc[MAIN]),
    .wbs_stb_i (b_stb[MAIN]),
    .wbs_we_i  (b_we[MAIN]),
    .wbs_sel_i (b_sel[MAIN]),
    .wbs_adr_i (b_adr[MAIN]),
    .wbs_dat_i (b_dat[MAIN]),
    .wbs_dat_o (b_rdat[32*MAIN +: 32]),
    .wbs_ack_o (b_ack[MAIN]),
    .h2c_data  (h2c_data),
    .h2c_valid (h2c_valid),
    .h2c_take  (h2c_take),
    .c2h_data  (c2h_data),
    .c2h_we    (c2h_we),
    .c2h_valid (c2h_valid),
    .irq       (irq)
  );

  for (genvar g = 0; g < NI - 1; g++) begin : g_sw
    localparam int NC = cfg_nc(g);
    logic [32*NC-1:0] s_h2c_d;
    logic [NC-1:0]    s_h2c_v;
    logic [NC-1:0]    s_c2h_v;
    logic             s_irq;

    wb_mailbox_bridge #(.NUM_CH(NC), .ACK_DELAY(cfg_ad(g))) u_dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (b_cyc[g]),
      .wbs_stb_i (b_stb[g]),
      .wbs_we_i  (b_we[g]),
      .wbs_sel_i (b_sel[g]),
      .wbs_adr_i (b_adr[g]),
      .wbs_dat_i (b_dat[g]),
      .wbs_dat_o (b_rdat[32*g +: 32]),
      .wbs_ack_o (b_ack[g]),
      .h2c_data  (s_h2c_d),
      .h2c_valid (s_h2c_v),
      .h2c_take  ('0),
      .c2h_data  ('0),
      .c2h_we    ('0),
      .c2h_valid (s_c2h_v),
      .irq       (s_irq)
    );
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the main instance (4 channels).
  logic [31:0] m_h2c [4];
  logic [31:0] m_c2h [4];
  logic [3:0]  m_hv, m_cv, m_ie;

  function automatic logic [31:0] m_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] r;
    r = 32'hFFFF_FFFF;
    if (idx < 4)       r = m_h2c[idx];
    else if (idx < 8)  r = m_c2h[idx - 4];
    else if (idx == 8) r = {12'h0, m_cv, 12'h0, m_hv};
    else if (idx == 9) r = {28'h0, m_ie};
    return r;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_h2c_valid"}, h2c_valid, m_hv);
    check({tag, "_c2h_valid"}, c2h_valid, m_cv);
    check({tag, "_irq"}, irq, |(m_cv & m_ie));
    check({tag, "_h2c_data"}, h2c_data, {m_h2c[3], m_h2c[2], m_h2c[1], m_h2c[0]});
  endtask

  // Core-side pulses (main instance only) fire on the edge that commits the access.
  task automatic xfer(input int g, input logic we, input logic [5:0] idx,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic [3:0] take_c, input logic [3:0] cwe_c, input logic [31:0] cdat,
                      output logic [31:0] rdat, output int lat);
    b_cyc[g] = 1'b1;
    b_stb[g] = 1'b1;
    b_we[g]  = we;
    b_adr[g] = {24'($urandom), idx, 2'($urandom)};
    b_dat[g] = dat;
    b_sel[g] = sel;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (g == MAIN && n == 2) begin
        h2c_take = take_c;
        c2h_we   = cwe_c;
        c2h_data = {4{cdat}};
      end
      @(posedge wb_clk_i); #1;
      h2c_take = '0;
      c2h_we   = '0;
      if (b_ack[g]) begin
        lat = n;
        break;
      end
    end
    rdat = b_rdat[32*g +: 32];
    b_cyc[g] = 1'b0;
    b_stb[g] = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic core(input logic [3:0] take, input logic [3:0] we, input logic [127:0] d);
    h2c_take = take;
    c2h_we   = we;
    c2h_data = d;
    @(posedge wb_clk_i); #1;
    h2c_take = '0;
    c2h_we   = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd, d;
  logic [3:0]  s;
  logic        ack_seen;
  int          lat, op, ch, idx, nc, ad;

  initial begin
    for (int g = 0; g < NI; g++) begin
      b_cyc[g] = 1'b0; b_stb[g] = 1'b0; b_we[g] = 1'b0;
      b_sel[g] = '0;   b_adr[g] = '0;   b_dat[g] = '0;
    end
    h2c_take = '0; c2h_we = '0; c2h_data = '0;
    for (int i = 0; i < 4; i++) begin
      m_h2c[i] = '0;
      m_c2h[i] = '0;
    end
    m_hv = '0; m_cv = '0; m_ie = '0;

    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    for (int g = 0; g < NI; g++) begin
      check("rst_ack", b_ack[g], 1'b0);
      check("rst_dat", b_rdat[32*g +: 32], 32'hFFFF_FFFF);
    end
    check_model("rst");

    // H2C write, latency, take
    xfer(MAIN, 1'b1, 6'd2, 32'hDEAD_BEEF, 4'hF, '0, '0, '0, rd, lat);
    m_h2c[2] = 32'hDEAD_BEEF; m_hv[2] = 1'b1;
    check("h2c_wr_lat", lat, 2);
    check("h2c2_data", h2c_data[95:64], 32'hDEAD_BEEF);
    check("h2c_valid_0100", h2c_valid, 4'b0100);
    core(4'b0100, '0, '0);
    m_hv[2] = 1'b0;
    check("take_clears", h2c_valid, 4'b0000);

    // byte mask
    xfer(MAIN, 1'b1, 6'd0, 32'h1122_3344, 4'hF, '0, '0, '0, rd, lat);
    xfer(MAIN, 1'b1, 6'd0, 32'hAABB_CCDD, 4'b0101, '0, '0, '0, rd, lat);
    m_h2c[0] = m_merge(m_merge(32'h0, 32'h1122_3344, 4'hF), 32'hAABB_CCDD, 4'b0101);
    m_hv[0] = 1'b1;
    xfer(MAIN, 1'b0, 6'd0, '0, 4'hF, '0, '0, '0, rd, lat);
    check("bytemask_rd", rd, 32'h11BB_33DD);
    check("bytemask_model", rd, m_read(0));

    // C2H, irq, status
    core(4'b0001, '0, '0);
    m_hv[0] = 1'b0;
    xfer(MAIN, 1'b1, 6'd9, 32'h0000_0002, 4'hF, '0, '0, '0, rd, lat);
    m_ie = 4'h2;
    core('0, 4'b0010, {32'h0, 32'h0, 32'hCAFE_F00D, 32'h0});
    m_c2h[1] = 32'hCAFE_F00D; m_cv[1] = 1'b1;
    check("irq_set", irq, 1'b1);
    xfer(MAIN, 1'b0, 6'd8, '0, 4'hF, '0, '0, '0, rd, lat);
    check("status", rd, 32'h0002_0000);
    xfer(MAIN, 1'b0, 6'd5, '0, 4'hF, '0, '0, '0, rd, lat);
    m_cv[1] = 1'b0;
    check("c2h1_rd", rd, 32'hCAFE_F00D);
    check("irq_drop", irq, 1'b0);

    // same-edge core write vs host read-clear
    core('0, 4'b0001, {96'h0, 32'h4});
    xfer(MAIN, 1'b0, 6'd4, '0, 4'hF, '0, 4'b0001, 32'h5, rd, lat);
    m_c2h[0] = 32'h5; m_cv[0] = 1'b1;
    check("race_old_word", rd, 32'h4);
    check("race_lat", lat, 2);
    check("race_valid", c2h_valid[0], 1'b1);
    xfer(MAIN, 1'b0, 6'd4, '0, 4'hF, '0, '0, '0, rd, lat);
    m_cv[0] = 1'b0;
    check("race_new_word", rd, 32'h5);

    // same-edge host write vs take
    xfer(MAIN, 1'b1, 6'd1, 32'h0102_0304, 4'hF, 4'b0010, '0, '0, rd, lat);
    m_h2c[1] = 32'h0102_0304; m_hv[1] = 1'b1;
    check_model("wr_vs_take");

    // unmapped index
    xfer(MAIN, 1'b0, 6'h3F, '0, 4'hF, '0, '0, '0, rd, lat);
    check("bad_idx_rd", rd, 32'hFFFF_FFFF);
    check("bad_idx_lat", lat, 2);

    // dropped cycle during WAIT (ACK_DELAY=4)
    b_cyc[6] = 1'b1; b_stb[6] = 1'b1; b_we[6] = 1'b1;
    b_adr[6] = 32'h4; b_dat[6] = 32'h55AA_55AA; b_sel[6] = 4'hF;
    ack_seen = 1'b0;
    repeat (2) begin
      @(posedge wb_clk_i); #1;
      ack_seen = ack_seen | b_ack[6];
    end
    b_cyc[6] = 1'b0; b_stb[6] = 1'b0;
    repeat (6) begin
      @(posedge wb_clk_i); #1;
      ack_seen = ack_seen | b_ack[6];
    end
    check("drop_no_ack", ack_seen, 1'b0);
    xfer(6, 1'b0, 6'd1, '0, 4'hF, '0, '0, '0, rd, lat);
    check("drop_no_write", rd, 32'h0);
    check("drop_lat", lat, 5);
    xfer(6, 1'b0, 6'd8, '0, 4'hF, '0, '0, '0, rd, lat);
    check("drop_status", rd, 32'h0);

    // parameter sweep
    for (int g = 0; g < 6; g++) begin
      nc = cfg_nc(g);
      ad = cfg_ad(g);
      d = $urandom;
      xfer(g, 1'b1, 6'd0, d, 4'hF, '0, '0, '0, rd, lat);
      check("sweep_wr_lat", lat, ad + 1);
      xfer(g, 1'b0, 6'(2 * nc), '0, 4'hF, '0, '0, '0, rd, lat);
      check("sweep_status", rd, 32'h1);
      check("sweep_rd_lat", lat, ad + 1);
      xfer(g, 1'b0, 6'(2 * nc + 1), '0, 4'hF, '0, '0, '0, rd, lat);
      check("sweep_irqen", rd, 32'h0);
      xfer(g, 1'b0, 6'd0, '0, 4'hF, '0, '0, '0, rd, lat);
      check("sweep_h2c0", rd, d);
    end

    // randomized traffic on the main instance
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      ch = $urandom_range(0, 3);
      d  = $urandom;
      s  = 4'($urandom);
      case (op)
        0: begin
          xfer(MAIN, 1'b1, 6'(ch), d, s, '0, '0, '0, rd, lat);
          m_h2c[ch] = m_merge(m_h2c[ch], d, s);
          m_hv[ch]  = 1'b1;
        end
        1: begin
          idx = $urandom_range(0, 11);
          if (idx == 11) idx = 63;
          xfer(MAIN, 1'b0, 6'(idx), '0, s, '0, '0, '0, rd, lat);
          check("rnd_read", rd, m_read(idx));
          if (idx >= 4 && idx < 8) m_cv[idx - 4] = 1'b0;
        end
        2: begin
          core('0, 4'(1 << ch), {4{d}});
          m_c2h[ch] = d;
          m_cv[ch]  = 1'b1;
        end
        3: begin
          core(4'(1 << ch), '0, '0);
          m_hv[ch] = 1'b0;
        end
        4: begin
          xfer(MAIN, 1'b1, 6'd9, d, s, '0, '0, '0, rd, lat);
          if (s[0]) m_ie = d[3:0];
        end
        default: begin
          idx = ($urandom_range(0, 1) == 1) ? $urandom_range(4, 8) : $urandom_range(10, 63);
          xfer(MAIN, 1'b1, 6'(idx), d, 4'hF, '0, '0, '0, rd, lat);
        end
      endcase
      if (op != 2 && op != 3) check("rnd_lat", lat, 2);
      check_model("rnd");
    end

    // async reset mid-WAIT
    xfer(MAIN, 1'b1, 6'd0, 32'h0BAD_F00D, 4'hF, '0, '0, '0, rd, lat);
    xfer(MAIN, 1'b0, 6'd0, '0, 4'hF, '0, '0, '0, rd, lat);
    check("pre_rst_rd", rd, 32'h0BAD_F00D);
    b_cyc[MAIN] = 1'b1; b_stb[MAIN] = 1'b1; b_we[MAIN] = 1'b1;
    b_adr[MAIN] = 32'hC; b_dat[MAIN] = 32'h1234_5678; b_sel[MAIN] = 4'hF;
    @(posedge wb_clk_i); #3;
    wb_rst_i = 1'b1;
    #1;
    check("arst_ack", b_ack[MAIN], 1'b0);
    check("arst_dat", b_rdat[32*MAIN +: 32], 32'hFFFF_FFFF);
    check("arst_valid", h2c_valid, 4'b0000);
    @(posedge wb_clk_i); #1;
    check("arst_ack_hold", b_ack[MAIN], 1'b0);
    b_cyc[MAIN] = 1'b0; b_stb[MAIN] = 1'b0;
    wb_rst_i = 1'b0;
    xfer(MAIN, 1'b0, 6'd3, '0, 4'hF, '0, '0, '0, rd, lat);
    check("arst_no_commit", rd, 32'h0);
    check("arst_lat", lat, 2);
    xfer(MAIN, 1'b0, 6'd9, '0, 4'hF, '0, '0, '0, rd, lat);
    check("arst_irqen", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
